imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'd4: byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024: largest accepted word count.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low (0 = reset).
REQ-005 in_valid  in  1  byte-stream valid.
REQ-006 in_data  in  8  byte-stream data.
REQ-007 in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-008 restart  in  1  single-cycle pulse; re-arms the loader from DONE or ERR.
REQ-009 mem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  out  32  instruction-memory byte address.
REQ-011 mem_wdata  out  32  instruction word.
REQ-012 core_rst  out  1  active-high reset to the core; held until the load completes.
REQ-013 done  out  1  load completed successfully.
REQ-014 error  out  1  load aborted.

Function
REQ-015 Frame format: 2-byte word count N (little-endian), then N words of 4 bytes each (little-endian), then, if checksum is enabled, a 4-byte trailer.
REQ-016 FSM states: HDR0, HDR1, DATA, CSUM, DONE, ERR.
REQ-017 HDR0: an accepted byte becomes N[7:0]; go to HDR1.
REQ-018 HDR1: an accepted byte becomes N[15:8], then:
- N == 0 -> DONE (or CSUM when checksum is enabled);
- N > MAX_WORDS -> ERR;
- otherwise -> DATA.
REQ-019 DATA: bytes are assembled into a word, low byte first.
- On the 4th byte, mem_we = 1 in the next cycle, with mem_wdata = the assembled word and mem_addr = BASE_ADDR + 4*k (k = word index from 0).
- After word N-1 is written: -> DONE (or CSUM).
REQ-020 Write latency: exactly 1 cycle from acceptance of the 4th byte to the mem_we pulse.
- mem_we is never high for two consecutive cycles.
REQ-021 in_ready: 1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERR.
- Bytes presented with in_ready = 0 are not consumed.
REQ-022 Stalls: gaps in in_valid of any length pause the assembly and do not corrupt it.
REQ-023 mem_addr arithmetic is modulo 2^32; wrap-around is not an error.
REQ-024 DONE: done = 1, core_rst = 0, mem_we = 0.
REQ-025 ERR: error = 1, core_rst = 1.
REQ-026 In every state other than DONE: core_rst = 1 and done = 0.
REQ-027 restart in DONE or ERR -> HDR0 in the next cycle.
- Byte counter, word counter and accumulator are cleared.
- core_rst returns to 1.
REQ-028 restart in any other state is ignored.
REQ-029 restart together with an accepted byte: restart wins, and the byte is not consumed because in_ready = 0 in DONE/ERR.

Reset
REQ-030 rst = 0 asynchronously forces:
- state = HDR0;
- mem_we = 0, mem_addr = 0, mem_wdata = 0;
- done = 0, error = 0, core_rst = 1;
- all counters and accumulators = 0.
REQ-031 Reset mid-frame discards the partial word; no mem_we is issued for it.
REQ-032 Release of rst takes effect at the first clk edge after rst rises.

Configuration
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN, when defined, adds checksum checking:
- a 32-bit accumulator sums every written word, modulo 2^32;
- after the last word, or directly from HDR1 when N == 0, the FSM enters CSUM and receives a 4-byte little-endian trailer;
- match -> DONE; mismatch -> ERR.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN:
- the CSUM state and the accumulator are absent;
- after the last word the FSM goes directly to DONE;
- error is asserted only for N > MAX_WORDS.

Verification
REQ-035 Basic load: N = 2, bytes 13 00 00 00 / 93 00 10 00 -> mem_we pulses (0x4, 0x00000013) then (0x8, 0x00100093); done = 1; core_rst = 0 one cycle after the second write.
REQ-036 Stalls: same frame with in_valid low for 3 cycles between every byte -> identical writes; each mem_we exactly 1 cycle after its 4th byte.
REQ-037 Empty frame: N = 0 (bytes 00 00), macro undefined -> no mem_we; done = 1 immediately after HDR1.
REQ-038 Oversize frame: N = 0x0401 with MAX_WORDS = 1024 -> error = 1, core_rst = 1, in_ready = 0; restart pulse -> HDR0, error = 0.
REQ-039 Checksum (macro defined): N = 1, word 0x00000013.
- Trailer 13 00 00 00 -> done = 1.
- Trailer 14 00 00 00 -> error = 1.
REQ-040 Reset mid-frame: rst low after 2 data bytes -> outputs take their reset values immediately; no mem_we; a fresh frame then loads starting at 0x4.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the IMEM loader.
// Ports: in_valid/in_data/in_ready (byte stream), mem_we/mem_addr/mem_wdata (memory writes).
// master = stream source / memory sink side, slave = the loader itself.
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Purpose: parses a framed byte stream (16-bit LE word count + LE words) into instruction-memory writes.
// Latency: mem_we rises exactly 1 cycle after the 4th byte of a word is accepted; done/core_rst follow the last write by 1 cycle.
// Backpressure: in_ready is high while loading and low in DONE/ERR; restart re-arms from DONE/ERR.
// Ports: clk, rst (async, active-low), bus (imem_loader_if.slave), restart (pulse), core_rst, done, error.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a 4-byte LE trailer equal to the mod-2^32 sum of all words.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'd4,
   parameter int          MAX_WORDS = 1024
) (
   input  logic               clk,
   input  logic               rst,
   imem_loader_if.slave       bus,
   input  logic               restart,
   output logic               core_rst,
   output logic               done,
   output logic               error
);

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      HDR0,
      HDR1,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE,
      ERR
   } state_t;

   // State entered once the last word (or an empty header) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t FINISH = CSUM;
`else
   localparam state_t FINISH = DONE;
`endif

   state_t      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [31:0] word_q, word_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        in_ready_q, in_ready_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        core_rst_q, core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
`endif

   logic        accept;
   logic [15:0] n_full;
   logic [31:0] full_word;
   logic [31:0] word_offset;

   assign accept      = bus.in_valid && in_ready_q;
   assign n_full      = {bus.in_data, n_q[7:0]};
   // Bytes shift in from the top, so after the 4th byte the word is little-endian assembled.
   assign full_word   = {bus.in_data, word_q[31:8]};
   assign word_offset = {14'd0, word_cnt_q, 2'b00};

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      case (state_q)
         HDR0: begin
            if (accept) begin
               n_d[7:0] = bus.in_data;
               state_d  = HDR1;
            end
         end
         HDR1: begin
            if (accept) begin
               n_d[15:8] = bus.in_data;
               if (n_full == 16'd0) begin
                  state_d = FINISH;
               end else if ({16'd0, n_full} > MAX_W) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_d     = full_word;
               if (byte_cnt_q == 2'd3) begin
                  word_d      = '0;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = full_word;
                  mem_addr_d  = BASE_ADDR + word_offset;   // wraps modulo 2^32
                  word_cnt_d  = word_cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum_d       = sum_q + full_word;
`endif
                  if (word_cnt_q == n_q - 16'd1) begin
                     state_d = FINISH;
                  end
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_d     = full_word;
               if (byte_cnt_q == 2'd3) begin
                  word_d  = '0;
                  state_d = (full_word == sum_q) ? DONE : ERR;
               end
            end
         end
`endif
         DONE, ERR: begin
            // in_ready is low here, so a byte coinciding with restart is never consumed.
            if (restart) begin
               state_d    = HDR0;
               n_d        = '0;
               byte_cnt_d = '0;
               word_cnt_d = '0;
               word_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d      = '0;
`endif
            end
         end
         default: state_d = HDR0;
      endcase

      // Outputs are registered from the next state. done is held back during
      // the final write so the core leaves reset only after its last word lands.
      in_ready_d = (state_d != DONE) && (state_d != ERR);
      done_d     = (state_d == DONE) && !mem_we_d;
      error_d    = (state_d == ERR);
      core_rst_d = !done_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= HDR0;
         n_q         <= '0;
         byte_cnt_q  <= '0;
         word_cnt_q  <= '0;
         word_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         in_ready_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         core_rst_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         byte_cnt_q  <= byte_cnt_d;
         word_cnt_q  <= word_cnt_d;
         word_q      <= word_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         in_ready_q  <= in_ready_d;
         done_q      <= done_d;
         error_q     <= error_d;
         core_rst_q  <= core_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign done          = done_q;
   assign error         = error_q;
   assign core_rst      = core_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream frames in, memory writes checked
// against a scoreboard of expected (address, data, cycle) entries.
// Default build exercises the plain loader; checksum frames run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic restart = 1'b0;
   logic core_rst, done, error;

   always #5 clk = ~clk;

   imem_loader_if bus ();

   imem_loader dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .restart  (restart),
      .core_rst (core_rst),
      .done     (done),
      .error    (error)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t  exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   last_acc = 0;
   logic prev_we = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Write monitor: every mem_we pulse must match the oldest expected write,
   // land exactly one cycle after its 4th byte, and never follow another pulse.
   wr_t e;
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         check("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
         n_checks++;
         assert (exp_q.size() > 0) n_pass++;
         else $error("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", bus.mem_addr, bus.mem_wdata);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", bus.mem_addr, e.addr);
            check("wr_data", bus.mem_wdata, e.data);
            check("wr_latency_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_we <= bus.mem_we;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      last_acc     = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] a, input logic [31:0] d, input int gap);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], gap);
      exp_q.push_back('{addr: a, data: d, cyc: last_acc});
   endtask

   // Header, up to two words, and (checksum build) the matching trailer.
   task automatic send_frame(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1, input int gap);
      logic [31:0] w[2];
      logic [31:0] sum;
      w[0] = w0;
      w[1] = w1;
      sum  = 32'd0;
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
      for (int k = 0; k < int'(n); k++) begin
         send_word(32'd4 + 32'(4 * k), w[k], gap);
         sum = sum + w[k];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      for (int i = 0; i < 4; i++) send_byte(sum[8*i +: 8], gap);
`else
      if (sum == 32'hFFFF_FFFF) bus.in_data = 8'h00;
`endif
   endtask

   task automatic wait_end(input int budget);
      int t = 0;
      while (done !== 1'b1 && error !== 1'b1 && t < budget) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_core_rst", {31'd0, core_rst}, 32'd1);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst = 1'b1;

      // Basic two-word load
      send_frame(16'd2, 32'h0000_0013, 32'h0010_0093, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      @(negedge clk);
      check("basic_core_rst_during_write", {31'd0, core_rst}, 32'd1);
      check("basic_done_during_write", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("basic_core_rst_after_write", {31'd0, core_rst}, 32'd0);
`else
      wait_end(20);
`endif
      check("basic_done", {31'd0, done}, 32'd1);
      check("basic_error", {31'd0, error}, 32'd0);
      check("basic_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("basic_all_written", 32'(exp_q.size()), 32'd0);

      // Bytes offered in DONE are not consumed, including on the restart edge
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      repeat (3) @(negedge clk);
      check("done_holds_with_valid", {31'd0, done}, 32'd1);
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart      = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("restart_done_clr", {31'd0, done}, 32'd0);
      check("restart_core_rst", {31'd0, core_rst}, 32'd1);
      check("restart_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Same frame with 3-cycle gaps between every byte
      send_frame(16'd2, 32'h0000_0013, 32'h0010_0093, 3);
      wait_end(20);
      check("stall_done", {31'd0, done}, 32'd1);
      check("stall_all_written", 32'(exp_q.size()), 32'd0);
      pulse_restart();

      // Empty frame
      send_frame(16'd0, 32'd0, 32'd0, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      @(negedge clk);
`else
      wait_end(20);
`endif
      check("empty_done", {31'd0, done}, 32'd1);
      check("empty_core_rst", {31'd0, core_rst}, 32'd0);
      pulse_restart();

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match and mismatch
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h4, 32'h0000_0013, 0);
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      wait_end(20);
      check("csum_match_done", {31'd0, done}, 32'd1);
      check("csum_match_error", {31'd0, error}, 32'd0);
      pulse_restart();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'h4, 32'h0000_0013, 0);
      send_byte(8'h14, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      wait_end(20);
      check("csum_bad_error", {31'd0, error}, 32'd1);
      check("csum_bad_done", {31'd0, done}, 32'd0);
      pulse_restart();
`endif

      // Oversize frame: 0x0401 words
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      @(negedge clk);
      check("over_error", {31'd0, error}, 32'd1);
      check("over_core_rst", {31'd0, core_rst}, 32'd1);
      check("over_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("over_done", {31'd0, done}, 32'd0);
      pulse_restart();
      check("over_restart_error", {31'd0, error}, 32'd0);
      check("over_restart_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Exactly MAX_WORDS is accepted; then reset after 2 data bytes
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      @(negedge clk);
      check("max_words_error", {31'd0, error}, 32'd0);
      check("max_words_in_ready", {31'd0, bus.in_ready}, 32'd1);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
      check("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_error", {31'd0, error}, 32'd0);
      check("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Fresh frame after reset starts at the base address again
      send_frame(16'd1, 32'hDEAD_BEEF, 32'd0, 0);
      wait_end(20);
      check("fresh_done", {31'd0, done}, 32'd1);
      repeat (3) @(negedge clk);
      check("final_all_written", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
